// File: rtl/bkg_map_ram.sv
// Writable background tile map: self-initialises to the arena pattern, serves a
// read-only video port and an acknowledged read/write game port, and tracks the wall count.
module bkg_map_ram #(
    parameter int COLS       = 20,
    parameter int ROWS       = 15,
    parameter int TILE_W     = 3,
    parameter int ADDR_W     = 9,
    parameter int WALL_CODE  = 6,
    parameter int FLOOR_CODE = 0,
    parameter int CNT_W      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    output logic              busy,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [TILE_W-1:0] vid_q,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic              gl_rd,
    input  logic              gl_wr,
    input  logic [TILE_W-1:0] gl_wdata,
    output logic [TILE_W-1:0] gl_rdata,
    output logic              gl_ack,
    output logic [CNT_W-1:0]  wall_cnt
);

    localparam int NTILES = COLS * ROWS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [TILE_W-1:0] WALL_T  = TILE_W'(WALL_CODE);
    localparam logic [TILE_W-1:0] FLOOR_T = TILE_W'(FLOOR_CODE);

    typedef enum logic [0:0] {INIT = 1'b0, IDLE = 1'b1} state_t;

    // Widened compare so the check stays correct when 2^ADDR_W equals the tile count.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(NTILES));
    endfunction

    function automatic logic [TILE_W-1:0] arena_tile(input logic [ROW_W-1:0] r,
                                                     input logic [COL_W-1:0] c);
        logic wall;
        wall = (r == {ROW_W{1'b0}}) || (r == ROW_W'(ROWS-1)) ||
               (c == {COL_W{1'b0}}) || (c == COL_W'(COLS-1)) ||
               (!r[0] && !c[0]);
        return wall ? WALL_T : FLOOR_T;
    endfunction

    state_t             state_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic [ADDR_W-1:0]  init_addr_r;
    logic [TILE_W-1:0]  map_r [0:NTILES-1];

    logic [TILE_W-1:0]  init_tile_s;
    logic               gl_in_range_s;
    logic [TILE_W-1:0]  gl_old_s;
    logic [TILE_W-1:0]  vid_tile_s;
    logic               accept_s;
    logic               gl_write_s;
    logic               mem_we_s;
    logic [ADDR_W-1:0]  mem_waddr_s;
    logic [TILE_W-1:0]  mem_wdata_s;
    logic [CNT_W-1:0]   cnt_next_s;

    // Request qualification, read muxes, memory write selection and wall-count next value.
    always_comb begin
        init_tile_s   = arena_tile(row_r, col_r);
        gl_in_range_s = in_range(gl_addr);
        gl_old_s      = gl_in_range_s ? map_r[gl_addr] : {TILE_W{1'b0}};
        vid_tile_s    = ((state_r == IDLE) && in_range(vid_addr)) ? map_r[vid_addr]
                                                                  : {TILE_W{1'b0}};
        accept_s      = (state_r == IDLE) && !load && (gl_rd || gl_wr);
        gl_write_s    = accept_s && gl_wr && gl_in_range_s;

        if (!rst_n) begin
            mem_we_s    = 1'b0;
            mem_waddr_s = {ADDR_W{1'b0}};
            mem_wdata_s = {TILE_W{1'b0}};
        end else if (state_r == INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = init_addr_r;
            mem_wdata_s = init_tile_s;
        end else if (gl_write_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = gl_addr;
            mem_wdata_s = gl_wdata;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = {ADDR_W{1'b0}};
            mem_wdata_s = {TILE_W{1'b0}};
        end

        cnt_next_s = wall_cnt;
        if (state_r == INIT) begin
            if (init_tile_s == WALL_T) begin
                cnt_next_s = wall_cnt + CNT_W'(1);
            end else begin
                cnt_next_s = wall_cnt;
            end
        end else if (gl_write_s) begin
            if ((gl_wdata == WALL_T) && (gl_old_s != WALL_T)) begin
                cnt_next_s = wall_cnt + CNT_W'(1);
            end else if ((gl_old_s == WALL_T) && (gl_wdata != WALL_T)) begin
                cnt_next_s = wall_cnt - CNT_W'(1);
            end else begin
                cnt_next_s = wall_cnt;
            end
        end else begin
            cnt_next_s = wall_cnt;
        end
    end

    // Tile storage; contents are not reset, the fill sequence defines them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            map_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with all outputs registered; load restarts the fill from tile 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= INIT;
            row_r       <= {ROW_W{1'b0}};
            col_r       <= {COL_W{1'b0}};
            init_addr_r <= {ADDR_W{1'b0}};
            busy        <= 1'b1;
            vid_q       <= {TILE_W{1'b0}};
            gl_rdata    <= {TILE_W{1'b0}};
            gl_ack      <= 1'b0;
            wall_cnt    <= {CNT_W{1'b0}};
        end else begin
            vid_q  <= vid_tile_s;
            gl_ack <= accept_s;
            if (accept_s) begin
                gl_rdata <= gl_old_s;
            end else begin
                gl_rdata <= gl_rdata;
            end

            if (load) begin
                state_r     <= INIT;
                row_r       <= {ROW_W{1'b0}};
                col_r       <= {COL_W{1'b0}};
                init_addr_r <= {ADDR_W{1'b0}};
                busy        <= 1'b1;
                wall_cnt    <= {CNT_W{1'b0}};
            end else begin
                wall_cnt <= cnt_next_s;
                case (state_r)
                    INIT: begin
                        init_addr_r <= init_addr_r + ADDR_W'(1);
                        if (col_r == COL_W'(COLS-1)) begin
                            col_r <= {COL_W{1'b0}};
                            if (row_r == ROW_W'(ROWS-1)) begin
                                row_r   <= {ROW_W{1'b0}};
                                state_r <= IDLE;
                                busy    <= 1'b0;
                            end else begin
                                row_r <= row_r + ROW_W'(1);
                            end
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    default: begin
                        state_r     <= INIT;
                        row_r       <= {ROW_W{1'b0}};
                        col_r       <= {COL_W{1'b0}};
                        init_addr_r <= {ADDR_W{1'b0}};
                        busy        <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/bkg_map_ram.md
Name: bkg_map_ram

Overview:
- Parametrised, writable successor to the fixed background tile ROMs.
- Holds the play-field tile map as a row-major array of ROWS×COLS tiles, TILE_W bits each.
- After reset or on request, self-initialises to the standard arena pattern: border walls plus even-row/even-column pillars.
- Serves the video path through a read-only port, and the game logic through a read/write port with acknowledge (e.g. destroyed bricks becoming floor).
- Maintains a live count of wall tiles.

Parameters:
- COLS, 20, tiles per row.
- ROWS, 15, tile rows.
- TILE_W, 3, bits per tile code.
- ADDR_W, 9, tile address width; must satisfy 2^ADDR_W ≥ COLS*ROWS.
- WALL_CODE, 6, tile code written for walls/pillars.
- FLOOR_CODE, 0, tile code written for all other tiles.
- CNT_W, 9, width of wall counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- load  in  1  one-cycle pulse: restart map initialisation.
- busy  out  1  high while initialising.
- vid_addr  in  ADDR_W  video tile address (row*COLS+col).
- vid_q  out  TILE_W  video tile code.
- gl_addr  in  ADDR_W  game-logic tile address.
- gl_rd  in  1  game read request.
- gl_wr  in  1  game write request.
- gl_wdata  in  TILE_W  write data.
- gl_rdata  out  TILE_W  tile value before the access.
- gl_ack  out  1  one-cycle request acknowledge.
- wall_cnt  out  CNT_W  number of tiles currently equal to WALL_CODE.

Interface decision (already decided): one clock, clk; reset rst_n is synchronous and active-low.

Behaviour:
- Reset values: busy=1, state=INIT, row/col counters=0, vid_q=0, gl_rdata=0, gl_ack=0, wall_cnt=0. Array contents are undefined until INIT completes.
- FSM states: INIT, IDLE.
- INIT
  - One tile written per clk, row-major, tracked with separate row/col counters (no divide).
  - Tile (r,c) = WALL_CODE if r==0, r==ROWS-1, c==0, c==COLS-1, or (r even and c even); otherwise FLOOR_CODE.
  - wall_cnt is cleared on entry and incremented for each WALL_CODE written.
  - The last write (r=ROWS-1, c=COLS-1) moves the state to IDLE, and busy falls on that same edge.
  - INIT lasts exactly COLS*ROWS cycles after reset release or after the load cycle.
- load
  - Sampled in either state; forces INIT from tile 0 on the next edge.
  - Asserted mid-INIT, it restarts the fill from 0.
  - It has priority over any same-cycle game request; that request is dropped, with no ack.
- Video port
  - Registered read, latency 1: vid_q(t+1) = map[vid_addr(t)].
  - vid_q=0 when vid_addr ≥ COLS*ROWS or while busy.
  - Read-first: a same-cycle game write to the same address returns the old value.
- Game port
  - Accepted only in IDLE with load=0; requests while busy are ignored.
  - gl_ack=1 exactly one cycle after an accepted request (gl_rd or gl_wr), together with gl_rdata = old map[gl_addr].
  - gl_wr writes gl_wdata at that edge. gl_rd and gl_wr together form a read-modify-write (old value returned, new value stored).
  - Back-to-back requests every cycle are supported.
  - gl_addr ≥ COLS*ROWS: ack still given, gl_rdata=0, no write, wall_cnt unchanged.
  - gl_rdata holds its value between acks.
- wall_cnt update on an accepted in-range write:
  - +1 if new==WALL_CODE and old!=WALL_CODE.
  - −1 if old==WALL_CODE and new!=WALL_CODE.
  - Otherwise unchanged.
  - Updated on the same edge as the write; never wraps in legal use.
- rst_n low mid-operation: all outputs take reset values on the next edge, and any pending ack is cancelled.

Test Plan (each line: stimulus -> required response; defaults):
- Release reset, hold idle -> busy=1 for exactly 300 cycles, then 0; wall_cnt=120. Video scan then returns addr0=6, addr1=6, addr21=0, addr42=6 (r2,c2), addr43=0, addr299=6.
- IDLE, gl_wr addr 43 data 6 -> next cycle gl_ack=1, gl_rdata=0, wall_cnt=121. A following gl_rd on 43 returns 6. A gl_wr on 43 with data 0 returns wall_cnt to 120.
- Same cycle: vid_addr=43 and gl_wr addr 43 data 6 (map holds 0) -> vid_q=0 next cycle. Re-read of 43 gives 6.
- gl_rd addr 310 and gl_wr addr 400 -> ack each cycle, gl_rdata=0, wall_cnt unchanged.
- load pulsed at INIT cycle 150 -> busy stays high for 300 more cycles. Final wall_cnt=120, and all earlier game writes are overwritten.
- gl_wr with busy=1, and gl_wr coincident with load in IDLE -> no gl_ack, no map change. rst_n low for 1 cycle mid-INIT -> outputs reset and a full 300-cycle INIT follows.
